// File: rtl/led_arbiter_pkg.sv
// Shared definitions for the LED bank arbiter: FSM state encoding and helpers.
package led_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_t;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit scanning ptr, ptr+1, ... with wrap.
module rr_pick
  import led_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  // Scanning from the farthest slot back to ptr lets the nearest hit overwrite the rest.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    winner = '0;
    valid  = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NUM_REQ]) begin
        winner = IDX_W'((int'(ptr) + k) % NUM_REQ);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_arbiter.sv
// Time-sliced round-robin owner of an active-low LED bank.
// Optional build macro LED_ARB_HEARTBEAT_EN: blink LED 0 while the bank is unowned.
module led_arbiter
  import led_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int LED_W        = 4,
  parameter int DWELL_CYCLES = 25_000_000,
  parameter int CNT_W        = 25
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst_L,
  input  logic [NUM_REQ-1:0]       i_Req,
  input  logic [NUM_REQ*LED_W-1:0] i_Data,
  output logic [NUM_REQ-1:0]       o_Grant,
  output logic                     o_Busy,
  output logic [LED_W-1:0]         o_LED
);

  localparam int               IDX_W    = idx_width(NUM_REQ);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [LED_W-1:0] LED_OFF  = '1;

  arb_state_t         state, next_state;
  logic [IDX_W-1:0]   ptr, owner, next_owner, win;
  logic               win_valid;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [NUM_REQ-1:0] owner_oh, next_oh;
  logic               expire, owner_req, others_req;
  logic [NUM_REQ-1:0] grant_d;
  logic [LED_W-1:0]   led_d, idle_led;

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req    (i_Req),
    .ptr    (ptr),
    .winner (win),
    .valid  (win_valid)
  );

  assign owner_oh   = NUM_REQ'(1) << owner;
  assign next_oh    = NUM_REQ'(1) << next_owner;
  assign expire     = (cnt == CNT_LAST);
  assign owner_req  = i_Req[owner];
  assign others_req = |(i_Req & ~owner_oh);

  // State register, owner, dwell counter and round-robin pointer.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state <= ST_IDLE;
      owner <= '0;
      cnt   <= '0;
      ptr   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state <= next_state;
      owner <= next_owner;
      cnt   <= cnt_next;
      if (state == ST_SHOW && next_state == ST_GAP)
        ptr <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);
    end
  end

  // Release and expiry-with-contention collapse into one GAP transition.
  always_comb begin
    next_state = state;
    next_owner = owner;
    cnt_next   = '0;
    unique case (state)
      ST_IDLE: begin
        if (win_valid) begin
          next_state = ST_SHOW;
          next_owner = win;
        end
      end
      ST_SHOW: begin
        if (!owner_req || (expire && others_req))
          next_state = ST_GAP;
        else
          cnt_next = expire ? '0 : cnt + CNT_W'(1);
      end
      ST_GAP:  next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

`ifdef LED_ARB_HEARTBEAT_EN
  logic [CNT_W-1:0] hb_cnt;
  logic             hb, hb_next;

  assign hb_next = (hb_cnt == CNT_LAST) ? ~hb : hb;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      hb_cnt <= '0;
      hb     <= 1'b0;
    end else begin
      hb_cnt <= (hb_cnt == CNT_LAST) ? '0 : hb_cnt + CNT_W'(1);
      hb     <= hb_next;
    end
  end

  always_comb begin
    idle_led    = LED_OFF;
    idle_led[0] = ~hb_next;
  end
`else
  assign idle_led = LED_OFF;
`endif

  // Outputs are decoded from the next state so they change on the same edge as the FSM.
  always_comb begin
    grant_d = '0;
    led_d   = LED_OFF;
    unique case (next_state)
      ST_SHOW: begin
        grant_d = next_oh;
        led_d   = ~i_Data[int'(next_owner) * LED_W +: LED_W];
      end
      ST_IDLE: led_d = idle_led;
      default: led_d = LED_OFF;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_Grant <= '0;
      o_Busy  <= 1'b0;
      o_LED   <= LED_OFF;
    end else begin
      o_Grant <= grant_d;
      o_Busy  <= (next_state == ST_SHOW);
      o_LED   <= led_d;
    end
  end

endmodule

// File: tb/tb_led_arbiter.sv
// Self-checking bench for led_arbiter: directed scenarios plus random traffic against an ownership model.
module tb_led_arbiter;

  localparam int NUM_REQ = 4;
  localparam int LED_W   = 4;
  localparam int DWELL   = 8;
  localparam int CNT_W   = 4;

  logic                     i_Clk;
  logic                     i_Rst_L;
  logic [NUM_REQ-1:0]       i_Req;
  logic [NUM_REQ*LED_W-1:0] i_Data;
  logic [NUM_REQ-1:0]       o_Grant;
  logic                     o_Busy;
  logic [LED_W-1:0]         o_LED;

  int errors = 0;
  int checks = 0;

  // Model: who owns the bank, how long they have held it, and whether the blank cycle is showing.
  bit m_own;
  bit m_gap;
  int m_owner;
  int m_age;
  int m_start;
  int m_hb_cnt;
  bit m_hb;

  led_arbiter #(
    .NUM_REQ(NUM_REQ), .LED_W(LED_W), .DWELL_CYCLES(DWELL), .CNT_W(CNT_W)
  ) dut (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Req   (i_Req),
    .i_Data  (i_Data),
    .o_Grant (o_Grant),
    .o_Busy  (o_Busy),
    .o_LED   (o_LED)
  );

  initial begin
    i_Clk = 1'b0;
    forever #5 i_Clk = ~i_Clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_own    = 0;
    m_gap    = 0;
    m_owner  = 0;
    m_age    = 0;
    m_start  = 0;
    m_hb_cnt = 0;
    m_hb     = 0;
  endtask

  task automatic model_edge(input logic [NUM_REQ-1:0] req);
    bit others;
    bit found;
    if (m_own) begin
      others = (req & ~(NUM_REQ'(1) << m_owner)) != 0;
      if (!req[m_owner] || (m_age == DWELL - 1 && others)) begin
        m_own   = 0;
        m_gap   = 1;
        m_start = (m_owner + 1) % NUM_REQ;
      end else begin
        m_age = (m_age == DWELL - 1) ? 0 : m_age + 1;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else begin
      found = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!found && req[(m_start + k) % NUM_REQ]) begin
          found   = 1;
          m_own   = 1;
          m_owner = (m_start + k) % NUM_REQ;
          m_age   = 0;
        end
      end
    end
    if (m_hb_cnt == DWELL - 1) begin
      m_hb_cnt = 0;
      m_hb     = !m_hb;
    end else begin
      m_hb_cnt++;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [LED_W-1:0]   exp_led;
    logic [NUM_REQ-1:0] exp_grant;
    exp_grant = m_own ? NUM_REQ'(1) << m_owner : '0;
    if (m_own) exp_led = ~i_Data[m_owner*LED_W +: LED_W];
    else if (m_gap) exp_led = '1;
    else begin
      exp_led = '1;
`ifdef LED_ARB_HEARTBEAT_EN
      exp_led[0] = ~m_hb;
`endif
    end
    check({tag, "_grant"}, 32'(o_Grant), 32'(exp_grant));
    check({tag, "_busy"},  32'(o_Busy),  32'(m_own));
    check({tag, "_led"},   32'(o_LED),   32'(exp_led));
  endtask

  task automatic step(input string tag, input logic [NUM_REQ-1:0] req, input logic [NUM_REQ*LED_W-1:0] data);
    i_Req  = req;
    i_Data = data;
    model_edge(req);
    @(posedge i_Clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*LED_W-1:0] data;
    int n;

    i_Rst_L = 1'b0;
    i_Req   = '0;
    i_Data  = '0;
    model_reset();
    #12;
    check_outputs("reset");
    i_Rst_L = 1'b1;

    // Single requester: grant after one edge, then renewed with no blank.
    data = 16'h0A00;
    step("single_first", 4'b0100, data);
    check("single_grant_const", 32'(o_Grant), 32'h4);
    check("single_led_const",   32'(o_LED),   32'h5);
    for (int i = 0; i < 20; i++) step("single", 4'b0100, data);

    // Round robin across requesters 0, 1, 3.
    data = 16'h96C3;
    for (int i = 0; i < 45; i++) step("rr", 4'b1011, data);

    // Early release: owner 1 drops at cnt 3 while requester 3 waits.
    n = 0;
    while (!(m_own && m_owner == 1 && m_age == 3) && n < 100) begin
      step("early_wait", 4'b1011, data);
      n++;
    end
    check("early_reached", 32'(n < 100), 32'h1);
    step("early_drop", 4'b1001, data);
    step("early_gap",  4'b1001, data);
    step("early_new",  4'b1001, data);
    check("early_grant_const", 32'(o_Grant), 32'h8);

    // Owner 0 releases exactly on its expiry cycle while requester 2 waits.
    n = 0;
    while (!(m_own && m_owner == 0 && m_age == DWELL - 1) && n < 100) begin
      step("simul_wait", 4'b0101, data);
      n++;
    end
    check("simul_reached", 32'(n < 100), 32'h1);
    step("simul_drop", 4'b0100, data);
    step("simul_gap",  4'b0100, data);
    step("simul_new",  4'b0100, data);
    check("simul_grant_const", 32'(o_Grant), 32'h4);

    // Owner data changes track with one edge of latency; non-owner data is ignored.
    data = 16'h0A00;
    step("track_a", 4'b0100, data);
    data = 16'h0300;
    step("track_b", 4'b0100, data);
    check("track_led_const", 32'(o_LED), 32'hC);
    data = 16'h030F;
    step("track_other", 4'b0100, data);
    check("track_other_const", 32'(o_LED), 32'hC);

    // Unowned bank: all off, or heartbeat blink in the macro build.
    for (int i = 0; i < 20; i++) step("idle", 4'b0000, data);

    // Random traffic with sticky requests.
    req = 4'b0000;
    for (int i = 0; i < 500; i++) begin
      for (int b = 0; b < NUM_REQ; b++)
        if ($urandom_range(5) == 0) req[b] = ~req[b];
      if ($urandom_range(3) == 0) data = 16'($urandom);
      step("rand", req, data);
    end

    // Asynchronous reset in the middle of a SHOW period.
    n = 0;
    while (!m_own && n < 100) begin
      step("rst_wait", 4'b0010, data);
      n++;
    end
    check("rst_reached", 32'(m_own), 32'h1);
    #2;
    i_Rst_L = 1'b0;
    model_reset();
    #1;
    check_outputs("async_reset");
    @(posedge i_Clk);
    @(negedge i_Clk);
    i_Rst_L = 1'b1;
    for (int i = 0; i < 12; i++) step("post_reset", 4'b0010, data);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
